// File: rtl/cache_arbiter.sv
// Round-robin arbiter granting one of the I-cache or D-cache line requests to the
// eviction buffer; the request is latched at grant and held until mem_resp.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_mem_read,
  input  logic [31:0]  i_mem_addr,
  output logic [255:0] i_mem_rdata,
  output logic         i_mem_resp,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [31:0]  d_mem_addr,
  input  logic [255:0] d_mem_wdata,
  output logic [255:0] d_mem_rdata,
  output logic         d_mem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state, state_nxt;
  logic   last_d;
  logic   i_pend, d_pend;

  assign i_pend = i_mem_read;
  assign d_pend = d_mem_read | d_mem_write;

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == SERVE_D && mem_resp)
        last_d <= 1'b1;
      else if (state == SERVE_I && mem_resp)
        last_d <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_pend && d_pend)
          state_nxt = last_d ? SERVE_I : SERVE_D;
        else if (i_pend)
          state_nxt = SERVE_I;
        else if (d_pend)
          state_nxt = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_mem_resp = 1'b0;
    d_mem_resp = 1'b0;
    case (state)
      SERVE_I: i_mem_resp = mem_resp;
      SERVE_D: d_mem_resp = mem_resp;
      default: ;
    endcase
  end

  // Downstream request is captured on the grant edge and frozen until completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (state_nxt == SERVE_I) begin
        mem_read  <= 1'b1;
        mem_write <= 1'b0;
        mem_addr  <= i_mem_addr;
      end else if (state_nxt == SERVE_D) begin
        mem_read  <= ~d_mem_write;
        mem_write <= d_mem_write;
        mem_addr  <= d_mem_addr;
        mem_wdata <= d_mem_wdata;
      end
    end else if (mem_resp) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

endmodule
